nonce_sequencer: RTL

- Drives the SHA round pipeline and the hash checker. Walks a nonce range and steps a 6-bit round count per nonce.
- After each hash it consumes the checker's 33-bit {flag, nonce} word.
- Winning nonces go to the host side over a valid/ready handshake. The search then resumes or stops at the range limit.
- Sits between the host/register interface and the hash datapath.

---
 rtl/sha_pkg.sv | 22 ++
 rtl/nonce_counter.sv | 42 ++++
 rtl/nonce_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared types and constants for the nonce search control path.
//   state_e    - nonce_sequencer FSM states
//   NONCE_W    - nonce width
//   CNT_W      - round counter width (one hash = 2**CNT_W cycles)
//   ROUND_LAST - last round index of a hash
//   FLAG_BIT   - position of the hash-zero flag in the checker word
package sha_pkg;

  localparam int NONCE_W = 32;
  localparam int CNT_W   = 6;
  localparam logic [CNT_W-1:0] ROUND_LAST = 6'd63;
  localparam int FLAG_BIT = 32;

  typedef enum logic [2:0] {
    IDLE,
    HASH,
    CHECK,
    REPORT,
    DONE
  } state_e;

endpackage

// File: rtl/nonce_counter.sv
// nonce_counter: loadable, enabled wrap-around nonce counter that also holds
// the inclusive range limit and flags when the current value equals it.
//   clk, n_rst  - clock, synchronous active-low reset
//   load        - capture base into value and limit_in into the limit register
//   base        - value loaded on load
//   limit_in    - inclusive limit loaded on load
//   inc         - advance value by one (mod 2**W); load wins over inc
//   value       - current nonce
//   at_limit    - value equals the stored limit
module nonce_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] base,
  input  logic [W-1:0] limit_in,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_limit
);

  logic [W-1:0] value_q;
  logic [W-1:0] limit_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      value_q <= '0;
      limit_q <= '0;
    end else if (load) begin
      value_q <= base;
      limit_q <= limit_in;
    end else if (inc) begin
      // natural overflow gives the base > limit wrap-around search
      value_q <= value_q + 1'b1;
    end
  end

  assign value    = value_q;
  assign at_limit = (value_q == limit_q);

endmodule

// File: rtl/nonce_sequencer.sv
// nonce_sequencer: walks a nonce range, stepping the SHA round counter per
// nonce, consumes the checker's {flag, nonce} word one cycle after the last
// round, and hands winning nonces to the host over valid/ready.
//   clk, n_rst       - clock, synchronous active-low reset
//   start            - begin a search (IDLE or DONE only)
//   abort            - terminate the search (priority over start)
//   nonce_base/limit - inclusive search range, sampled on accepted start
//   flag_plus_nonce  - {hash-zero flag, latched nonce} from the checker
//   count            - round index to datapath/checker
//   nonce            - nonce being hashed
//   busy             - not IDLE
//   found_valid/found_nonce/found_ready - winning nonce handshake
//   exhausted        - range finished, sticky until next start
import sha_pkg::*;

module nonce_sequencer #(
  parameter int NONCE_W = sha_pkg::NONCE_W,
  parameter int CNT_W   = sha_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic [NONCE_W:0]   flag_plus_nonce,
  output logic [CNT_W-1:0]   count,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  input  logic               found_ready,
  output logic               exhausted
);

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fv_q, fv_d;
  logic [NONCE_W-1:0] fn_q, fn_d;
  logic               ex_q, ex_d;
  logic               busy_q;
  logic               ld, inc;
  logic               at_limit;
  logic               xfer;
  logic               flag;

  // flag sits just above the nonce field of the checker word
  assign flag = flag_plus_nonce[NONCE_W];
  assign xfer = fv_q & found_ready;

  nonce_counter #(.W(NONCE_W)) u_nonce (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (ld),
    .base     (nonce_base),
    .limit_in (nonce_limit),
    .inc      (inc),
    .value    (nonce),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fv_d    = fv_q;
    fn_d    = fn_q;
    ex_d    = ex_q;
    ld      = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          ld      = 1'b1;
          count_d = '0;
          ex_d    = 1'b0;
          state_d = HASH;
        end
      end
      HASH: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == CNT_LAST) begin
          state_d = CHECK;   // count parks at the last round during CHECK
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      CHECK: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (flag) begin
          fn_d    = flag_plus_nonce[NONCE_W-1:0];
          fv_d    = 1'b1;
          state_d = REPORT;
        end else if (at_limit) begin
          ex_d    = 1'b1;
          count_d = '0;
          state_d = DONE;
        end else begin
          inc     = 1'b1;
          count_d = '0;
          state_d = HASH;
        end
      end
      REPORT: begin
        // a handshake in the same cycle as abort still completes the transfer
        if (xfer || abort) begin
          fv_d    = 1'b0;
          count_d = '0;
          if (abort) begin
            state_d = IDLE;
          end else if (at_limit) begin
            ex_d    = 1'b1;
            state_d = DONE;
          end else begin
            inc     = 1'b1;
            state_d = HASH;
          end
        end
      end
      DONE: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (start) begin
          ld      = 1'b1;
          count_d = '0;
          ex_d    = 1'b0;
          state_d = HASH;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      fv_q    <= 1'b0;
      fn_q    <= '0;
      ex_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fv_q    <= fv_d;
      fn_q    <= fn_d;
      ex_q    <= ex_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign count       = count_q;
  assign busy        = busy_q;
  assign found_valid = fv_q;
  assign found_nonce = fn_q;
  assign exhausted   = ex_q;

endmodule
